// File: rtl/collision_pkg.sv
// Shared scan FSM state type and default playfield geometry, used by the
// collision scanner, renderer and meteor mover.
package collision_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    localparam int SHIP_W      = 40;
    localparam int SHIP_H      = 15;
    localparam int METEOR_SIZE = 30;
    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;

endpackage

// File: rtl/collision_scanner_rect_overlap.sv
// Combinational test of one meteor square against the ship rectangle: both
// objects must be fully on screen and strictly overlap (touching edges miss).
module rect_overlap #(
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int SHIP_W      = collision_pkg::SHIP_W,
    parameter int SHIP_H      = collision_pkg::SHIP_H,
    parameter int METEOR_SIZE = collision_pkg::METEOR_SIZE,
    parameter int SCREEN_W    = collision_pkg::SCREEN_W,
    parameter int SCREEN_H    = collision_pkg::SCREEN_H
) (
    input  logic [X_W-1:0] ship_x,
    input  logic [Y_W-1:0] ship_y,
    input  logic [X_W-1:0] meteor_x,
    input  logic [Y_W-1:0] meteor_y,
    input  logic           active,
    output logic           hit
);

    // One bit of headroom so edge sums never wrap.
    logic [X_W:0] sx, mx;
    logic [Y_W:0] sy, my;
    logic         on_screen, x_overlap, y_overlap;

    assign sx = {1'b0, ship_x};
    assign sy = {1'b0, ship_y};
    assign mx = {1'b0, meteor_x};
    assign my = {1'b0, meteor_y};

    assign on_screen = (mx <= (X_W+1)'(SCREEN_W - METEOR_SIZE)) &&
                       (my <= (Y_W+1)'(SCREEN_H - METEOR_SIZE)) &&
                       (sx <= (X_W+1)'(SCREEN_W - SHIP_W)) &&
                       (sy <= (Y_W+1)'(SCREEN_H - SHIP_H));

    assign x_overlap = (mx + (X_W+1)'(METEOR_SIZE) > sx) && (mx < sx + (X_W+1)'(SHIP_W));
    assign y_overlap = (my + (Y_W+1)'(METEOR_SIZE) > sy) && (my < sy + (Y_W+1)'(SHIP_H));

    assign hit = active && on_screen && x_overlap && y_overlap;

endmodule

// File: rtl/collision_scanner.sv
// Frame-synchronous ship/meteor collision scanner: snapshots on start, tests one
// meteor per clock, holds registered results. Optional COLLISION_GRACE_EN masks hits.
module collision_scanner #(
    parameter int N_METEORS   = 6,
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int SHIP_W      = collision_pkg::SHIP_W,
    parameter int SHIP_H      = collision_pkg::SHIP_H,
    parameter int METEOR_SIZE = collision_pkg::METEOR_SIZE,
    parameter int SCREEN_W    = collision_pkg::SCREEN_W,
    parameter int SCREEN_H    = collision_pkg::SCREEN_H
`ifdef COLLISION_GRACE_EN
    ,
    parameter int GRACE_FRAMES = 60
`endif
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [X_W-1:0]                 ship_x,
    input  logic [Y_W-1:0]                 ship_y,
    input  logic [X_W-1:0]                 meteor_x [N_METEORS],
    input  logic [Y_W-1:0]                 meteor_y [N_METEORS],
    input  logic [N_METEORS-1:0]           meteor_active,
    output logic                           busy,
    output logic                           done,
    output logic                           collision,
    output logic [N_METEORS-1:0]           meteor_collisions,
    output logic [$clog2(N_METEORS+1)-1:0] hit_count,
    output logic [$clog2(N_METEORS)-1:0]   first_hit_idx
`ifdef COLLISION_GRACE_EN
    ,
    output logic                           grace_active
`endif
);
    import collision_pkg::*;

    localparam int IDX_W = $clog2(N_METEORS);
    localparam int CNT_W = $clog2(N_METEORS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_METEORS - 1);

    scan_state_t          state;
    logic [IDX_W-1:0]     idx;
    logic [X_W-1:0]       ship_x_q;
    logic [Y_W-1:0]       ship_y_q;
    logic [X_W-1:0]       meteor_x_q [N_METEORS];
    logic [Y_W-1:0]       meteor_y_q [N_METEORS];
    logic [N_METEORS-1:0] active_q, acc_mask, scan_mask, load_mask;
    logic [X_W-1:0]       sel_x;
    logic [Y_W-1:0]       sel_y;
    logic                 sel_active, sel_hit;
    logic [CNT_W-1:0]     load_count;
    logic [IDX_W-1:0]     load_first;
    logic                 load_found;

    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_active = 1'b0;
        for (int i = 0; i < N_METEORS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_x      = meteor_x_q[i];
                sel_y      = meteor_y_q[i];
                sel_active = active_q[i];
            end
        end
    end

    rect_overlap #(
        .X_W(X_W), .Y_W(Y_W), .SHIP_W(SHIP_W), .SHIP_H(SHIP_H),
        .METEOR_SIZE(METEOR_SIZE), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
    ) u_overlap (
        .ship_x(ship_x_q), .ship_y(ship_y_q),
        .meteor_x(sel_x), .meteor_y(sel_y),
        .active(sel_active), .hit(sel_hit)
    );

    // Accumulated mask including the meteor tested this cycle.
    always_comb begin
        scan_mask = acc_mask;
        for (int i = 0; i < N_METEORS; i++) begin
            if (idx == IDX_W'(i)) scan_mask[i] = sel_hit;
        end
    end

`ifdef COLLISION_GRACE_EN
    localparam int GRACE_W = $clog2(GRACE_FRAMES + 1);
    logic [GRACE_W-1:0] grace_cnt;
    assign load_mask    = (grace_cnt != '0) ? '0 : scan_mask;
    assign grace_active = (grace_cnt != '0);
`else
    assign load_mask = scan_mask;
`endif

    always_comb begin
        load_count = '0;
        load_first = '0;
        load_found = 1'b0;
        for (int i = 0; i < N_METEORS; i++) begin
            if (load_mask[i]) begin
                load_count = load_count + CNT_W'(1);
                if (!load_found) begin
                    load_first = IDX_W'(i);
                    load_found = 1'b1;
                end
            end
        end
    end

    // Results load on the edge into DONE so they are valid alongside the done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            idx               <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            collision         <= 1'b0;
            meteor_collisions <= '0;
            hit_count         <= '0;
            first_hit_idx     <= '0;
            ship_x_q          <= '0;
            ship_y_q          <= '0;
            active_q          <= '0;
            acc_mask          <= '0;
            for (int i = 0; i < N_METEORS; i++) begin
                meteor_x_q[i] <= '0;
                meteor_y_q[i] <= '0;
            end
`ifdef COLLISION_GRACE_EN
            grace_cnt         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SCAN;
                        busy     <= 1'b1;
                        idx      <= '0;
                        acc_mask <= '0;
                        ship_x_q <= ship_x;
                        ship_y_q <= ship_y;
                        active_q <= meteor_active;
                        for (int i = 0; i < N_METEORS; i++) begin
                            meteor_x_q[i] <= meteor_x[i];
                            meteor_y_q[i] <= meteor_y[i];
                        end
                    end
                end
                SCAN: begin
                    acc_mask <= scan_mask;
                    if (idx == LAST_IDX) begin
                        state             <= DONE;
                        idx               <= '0;
                        done              <= 1'b1;
                        meteor_collisions <= load_mask;
                        collision         <= |load_mask;
                        hit_count         <= load_count;
                        first_hit_idx     <= load_first;
`ifdef COLLISION_GRACE_EN
                        if (grace_cnt != '0)
                            grace_cnt <= grace_cnt - GRACE_W'(1);
                        else if (scan_mask != '0)
                            grace_cnt <= GRACE_W'(GRACE_FRAMES);
`endif
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_collision_scanner.sv
// Bench for collision_scanner: cycle-level behavioural model with expected-mask
// queue, directed geometry/timing cases and randomized frames.
module tb_collision_scanner;

    localparam int N  = 6;
    localparam int G  = 2;
    localparam int SW = 640, SH = 480, PW = 40, PH = 15, MS = 30;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [9:0] ship_x;
    logic [8:0] ship_y;
    logic [9:0] meteor_x [N];
    logic [8:0] meteor_y [N];
    logic [5:0] meteor_active;
    logic       busy, done, collision;
    logic [5:0] meteor_collisions;
    logic [2:0] hit_count;
    logic [2:0] first_hit_idx;
`ifdef COLLISION_GRACE_EN
    logic       grace_active;
`endif

    int checks = 0;
    int errors = 0;

    collision_scanner #(
        .N_METEORS(N)
`ifdef COLLISION_GRACE_EN
        , .GRACE_FRAMES(G)
`endif
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .ship_x(ship_x), .ship_y(ship_y),
        .meteor_x(meteor_x), .meteor_y(meteor_y), .meteor_active(meteor_active),
        .busy(busy), .done(done), .collision(collision),
        .meteor_collisions(meteor_collisions), .hit_count(hit_count),
        .first_hit_idx(first_hit_idx)
`ifdef COLLISION_GRACE_EN
        , .grace_active(grace_active)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // behavioural model: a frame's result is decided entirely by the inputs
    // seen on the accepted start edge and appears N+1 cycles later
    function automatic bit ref_hit(int sx, int sy, int mx, int my, bit a);
        return a && mx <= SW - MS && my <= SH - MS && sx <= SW - PW && sy <= SH - PH
               && mx + MS > sx && mx < sx + PW && my + MS > sy && my < sy + PH;
    endfunction

    function automatic logic [N-1:0] ref_mask();
        logic [N-1:0] m;
        for (int i = 0; i < N; i++)
            m[i] = ref_hit(int'(ship_x), int'(ship_y), int'(meteor_x[i]), int'(meteor_y[i]),
                           meteor_active[i]);
        return m;
    endfunction

    logic [N-1:0] exp_q[$];
    int           m_cnt = 0;
    int           m_grace = 0;
    logic         m_busy = 1'b0, m_done = 1'b0;
    logic [N-1:0] m_mask = '0;
    int           m_count = 0, m_first = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt = 0; m_busy = 1'b0; m_done = 1'b0; m_mask = '0;
            m_count = 0; m_first = 0; m_grace = 0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            if (m_cnt == 0) begin
                if (start) begin
                    exp_q.push_back(ref_mask());
                    m_cnt  = 1;
                    m_busy = 1'b1;
                end
            end else if (m_cnt == N + 1) begin
                m_cnt  = 0;
                m_busy = 1'b0;
            end else begin
                m_cnt++;
                if (m_cnt == N + 1) begin
                    logic [N-1:0] raw;
                    raw    = exp_q.pop_front();
                    m_done = 1'b1;
                    m_mask = raw;
`ifdef COLLISION_GRACE_EN
                    if (m_grace != 0) begin
                        m_mask = '0;
                        m_grace--;
                    end else if (raw != 0) begin
                        m_grace = G;
                    end
`endif
                    m_count = $countones(m_mask);
                    m_first = 0;
                    for (int i = N - 1; i >= 0; i--)
                        if (m_mask[i]) m_first = i;
                end
            end
        end
    end

    // compare process: every output, every cycle
    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("collision", 32'(collision), 32'(|m_mask));
        check("mask", 32'(meteor_collisions), 32'(m_mask));
        check("hit_count", 32'(hit_count), 32'(m_count));
        check("first_hit_idx", 32'(first_hit_idx), 32'(m_first));
`ifdef COLLISION_GRACE_EN
        check("grace_active", 32'(grace_active), 32'(m_grace != 0));
`endif
    end

    // driver tasks
    task automatic clear_inputs();
        ship_x = 10'd300; ship_y = 9'd400;
        for (int i = 0; i < N; i++) begin
            meteor_x[i] = 10'd0; meteor_y[i] = 9'd0;
        end
        meteor_active = '0;
    endtask

    task automatic set_meteor(input int i, input int x, input int y);
        meteor_x[i] = 10'(x);
        meteor_y[i] = 9'(y);
        meteor_active[i] = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
    endtask

    task automatic start_scan();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        bit found = 1'b0;
        cyc = 0;
        while (!found && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done) found = 1'b1;
        end
        check("done_seen", 32'(found), 32'd1);
    endtask

    task automatic count_dones(output int n);
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    task automatic scan_expect(input string name, input logic [5:0] mask,
                               input int cnt, input int first);
        int cyc;
        start_scan();
        wait_done(cyc);
        check({name, "_latency"}, 32'(cyc), 32'd7);
        check({name, "_mask"}, 32'(meteor_collisions), 32'(mask));
        check({name, "_collision"}, 32'(collision), 32'(mask != 0));
        check({name, "_count"}, 32'(hit_count), 32'(cnt));
        check({name, "_first"}, 32'(first_hit_idx), 32'(first));
    endtask

    task automatic randomize_inputs();
        int v;
        if ($urandom_range(0, 4) == 0) begin
            ship_x = 10'($urandom_range(0, 1023));
            ship_y = 9'($urandom_range(0, 511));
        end else begin
            ship_x = 10'($urandom_range(0, 620));
            ship_y = 9'($urandom_range(0, 475));
        end
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                meteor_x[i] = 10'($urandom_range(0, 1023));
                meteor_y[i] = 9'($urandom_range(0, 511));
            end else begin
                v = int'(ship_x) + int'($urandom_range(0, 120)) - 60;
                meteor_x[i] = 10'((v < 0) ? 0 : v);
                v = int'(ship_y) + int'($urandom_range(0, 80)) - 40;
                meteor_y[i] = 9'((v < 0) ? 0 : v);
            end
        end
        meteor_active = 6'($urandom_range(0, 63));
    endtask

    initial begin
        int n, cyc;
        reset = 1'b1;
        start = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_mask", 32'(meteor_collisions), 32'd0);
        check("reset_first", 32'(first_hit_idx), 32'd0);

`ifndef COLLISION_GRACE_EN
        clear_inputs();
        set_meteor(2, 310, 390);
        scan_expect("single", 6'b000100, 1, 2);

        clear_inputs();
        set_meteor(0, 270, 400);
        set_meteor(1, 340, 400);
        set_meteor(3, 300, 370);
        set_meteor(5, 300, 415);
        scan_expect("touching", 6'b000000, 0, 0);

        clear_inputs();
        set_meteor(1, 320, 395);
        set_meteor(4, 290, 405);
        scan_expect("pair", 6'b010010, 2, 1);

        clear_inputs();
        set_meteor(2, 310, 460);
        set_meteor(3, 310, 395);
        meteor_active[3] = 1'b0;
        scan_expect("offscreen_inactive", 6'b000000, 0, 0);

        clear_inputs();
        ship_y = 9'd466;
        set_meteor(0, 310, 450);
        scan_expect("ship_offscreen", 6'b000000, 0, 0);

        clear_inputs();
        ship_y = 9'd465;
        set_meteor(0, 310, 450);
        scan_expect("ship_bottom_edge", 6'b000001, 1, 0);
`endif

        // restart and input changes during a scan must not matter
        do_reset();
        clear_inputs();
        set_meteor(2, 310, 390);
        start_scan();
        @(posedge clk); #2;
        @(posedge clk); #2 start = 1'b1;
        for (int i = 0; i < N; i++) set_meteor(i, 305, 395);
        @(posedge clk); #2 start = 1'b0;
        wait_done(cyc);
        check("midscan_mask", 32'(meteor_collisions), 32'h04);
        check("midscan_first", 32'(first_hit_idx), 32'd2);
        count_dones(n);
        check("midscan_not_queued", 32'(n), 32'd0);

        // reset during a scan aborts it
        clear_inputs();
        set_meteor(2, 310, 390);
        start_scan();
        repeat (3) begin
            @(posedge clk); #2;
        end
        reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
        check("abort_mask", 32'(meteor_collisions), 32'd0);
        check("abort_collision", 32'(collision), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        count_dones(n);
        check("abort_no_done", 32'(n), 32'd0);

`ifdef COLLISION_GRACE_EN
        begin
            logic exp_seq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
            for (int k = 0; k < 4; k++) begin
                start_scan();
                wait_done(cyc);
                check($sformatf("grace_scan%0d", k), 32'(collision), 32'(exp_seq[k]));
            end
        end
`endif

        // randomized frames, including restarts, mid-scan moves and resets
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #2;
            reset = ($urandom_range(0, 399) == 0);
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) randomize_inputs();
        end
        @(posedge clk); #2;
        reset = 1'b0;
        start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
